// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request
// outstanding to the instruction cache, and holds one fetched instruction
// for IF/ID while decode stalls. A taken branch/jump redirects the PC and
// squashes any wrong-path fetch that is still in flight.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0004,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic        icache_valid,
    input  logic [31:0] icache_inst,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        cache_stall
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_FULL
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic [31:0] buf_pc, buf_pc_next;
    logic [31:0] buf_inst, buf_inst_next;
    logic        buf_valid, buf_valid_next;
    logic        kill, kill_next;

    // State and datapath registers; reset takes effect immediately, even
    // with a request outstanding, so any late response lands in S_BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_BOOT;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            buf_pc    <= 32'h0;
            buf_inst  <= NOP_INST;
            buf_valid <= 1'b0;
            kill      <= 1'b0;
        end else begin
            state     <= state_next;
            fetch_pc  <= fetch_pc_next;
            req_pc    <= req_pc_next;
            buf_pc    <= buf_pc_next;
            buf_inst  <= buf_inst_next;
            buf_valid <= buf_valid_next;
            kill      <= kill_next;
        end
    end

    // Next-state, request handshake and redirect handling.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        req_pc_next    = req_pc;
        buf_pc_next    = buf_pc;
        buf_inst_next  = buf_inst;
        buf_valid_next = buf_valid;
        kill_next      = kill;
        icache_req     = 1'b0;
        icache_addr    = fetch_pc;

        case (state)
            S_BOOT: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                // A redirect suppresses the request so the old PC is never fetched.
                icache_req = !jb;
                if (jb) begin
                    fetch_pc_next = jb_target;
                end else if (icache_ready) begin
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + STEP;
                    state_next    = S_WAIT;
                end
            end

            S_WAIT: begin
                if (icache_valid) begin
                    if (kill || jb) begin
                        // Wrong-path response: drop it and refetch.
                        kill_next  = 1'b0;
                        state_next = S_REQ;
                        if (jb) begin
                            fetch_pc_next = jb_target;
                        end
                    end else begin
                        buf_pc_next    = req_pc;
                        buf_inst_next  = icache_inst;
                        buf_valid_next = 1'b1;
                        state_next     = S_FULL;
                    end
                end else if (jb) begin
                    // Response still pending; remember to discard it.
                    fetch_pc_next = jb_target;
                    kill_next     = 1'b1;
                end
            end

            S_FULL: begin
                if (jb) begin
                    buf_valid_next = 1'b0;
                    fetch_pc_next  = jb_target;
                    state_next     = S_REQ;
                end else if (!stall) begin
                    // Decode takes the buffered instruction at this edge, so
                    // the next fetch can be launched in the same cycle.
                    buf_valid_next = 1'b0;
                    icache_req     = 1'b1;
                    if (icache_ready) begin
                        req_pc_next   = fetch_pc;
                        fetch_pc_next = fetch_pc + STEP;
                        state_next    = S_WAIT;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end

            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    // Outputs to IF/ID: a bubble when empty; stall is dropped during a
    // redirect so IF/ID flushes instead of holding wrong-path contents.
    assign pc_out      = buf_valid ? buf_pc : 32'h0;
    assign inst_out    = buf_valid ? buf_inst : NOP_INST;
    assign cache_stall = !buf_valid && !jb;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction cache and
// scoreboard queues of expected request addresses and delivered PCs.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0004;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        jb;
    logic [31:0] jb_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        cache_stall;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_pc[$];

    // Behavioural cache state
    int          cache_lat = 1;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'h0;
    logic        prev_vis  = 1'b0;

    if_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .jb           (jb),
        .jb_target    (jb_target),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_ready (icache_ready),
        .icache_valid (icache_valid),
        .icache_inst  (icache_inst),
        .pc_out       (pc_out),
        .inst_out     (inst_out),
        .cache_stall  (cache_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: check handshake and IF/ID outputs against the scoreboard,
    // advance to the next edge, then update the cache response.
    task automatic tick();
        logic        hs;
        logic [31:0] hs_addr;
        logic        vis;
        #1;
        hs      = icache_req && icache_ready;
        hs_addr = icache_addr;
        if (hs) begin
            $display("req  addr=%h", hs_addr);
            if (exp_addr.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL req_addr: observed %h expected no request", hs_addr);
            end else begin
                chk("req_addr", hs_addr, exp_addr.pop_front());
            end
        end
        vis = !cache_stall && !jb;
        if (jb) begin
            prev_vis = 1'b0;
        end else begin
            if (vis && !prev_vis) begin
                $display("out  pc=%h inst=%h", pc_out, inst_out);
                if (exp_pc.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $error("FAIL out_pc: observed %h expected no instruction", pc_out);
                end else begin
                    logic [31:0] e;
                    e = exp_pc.pop_front();
                    chk("out_pc", pc_out, e);
                    chk("out_inst", inst_out, mem_of(e));
                end
            end else if (!vis) begin
                chk("empty_pc", pc_out, 32'h0);
                chk("empty_inst", inst_out, NOP);
            end
            prev_vis = vis;
        end
        @(posedge clk);
        #1;
        icache_valid = 1'b0;
        if (hs) begin
            pend_cnt  = cache_lat;
            pend_addr = hs_addr;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                icache_valid = 1'b1;
                icache_inst  = mem_of(pend_addr);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_inst"}, inst_out, NOP);
        chk({tag, "_cstall"}, {31'h0, cache_stall}, 32'h1);
        chk({tag, "_req"}, {31'h0, icache_req}, 32'h0);
    endtask

    initial begin
        rst_n        = 1'b1;
        stall        = 1'b0;
        jb           = 1'b0;
        jb_target    = 32'h0;
        icache_ready = 1'b1;
        icache_valid = 1'b0;
        icache_inst  = 32'h0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        settle();
        chk_reset_outputs("reset");

        // Sequential fetch, 1-cycle cache, no stalls
        rst_n = 1'b1;                       // c0: BOOT
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_pc.push_back(32'h0);
        exp_pc.push_back(32'h4);
        exp_pc.push_back(32'h8);
        repeat (4) tick();                  // c0..c3
        settle();                           // c4: WAIT, empty
        chk("gap_cstall", {31'h0, cache_stall}, 32'h1);
        chk("gap_inst", inst_out, NOP);
        repeat (3) tick();                  // c4..c6

        // Decode stall while holding PC 0x8
        exp_addr.push_back(32'hC);
        for (int i = 0; i < 3; i++) begin   // c7..c9
            stall = 1'b1;
            settle();
            chk("stall_pc", pc_out, 32'h8);
            chk("stall_inst", inst_out, mem_of(32'h8));
            chk("stall_req", {31'h0, icache_req}, 32'h0);
            tick();
        end
        stall     = 1'b0;
        cache_lat = 2;
        settle();
        chk("release_req", {31'h0, icache_req}, 32'h1);
        tick();                             // c10: request 0xC
        cache_lat = 1;

        // Redirect while the 0xC response is still pending
        jb        = 1'b1;
        jb_target = 32'h100;
        settle();
        chk("jb_wait_cstall", {31'h0, cache_stall}, 32'h0);
        tick();                             // c11
        jb = 1'b0;
        exp_addr.push_back(32'h100);
        exp_pc.push_back(32'h100);
        tick();                             // c12: stale response dropped
        tick();                             // c13: request 0x100
        tick();                             // c14

        // Redirect while full and stalled
        stall = 1'b1;
        settle();
        chk("full_pc", pc_out, 32'h100);
        tick();                             // c15
        jb        = 1'b1;
        jb_target = 32'h200;
        settle();
        chk("jb_full_cstall", {31'h0, cache_stall}, 32'h0);
        chk("jb_full_req", {31'h0, icache_req}, 32'h0);
        tick();                             // c16
        jb    = 1'b0;
        stall = 1'b0;
        exp_addr.push_back(32'h200);
        exp_pc.push_back(32'h200);

        // Cache not ready for 4 cycles
        icache_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin   // c17..c20
            settle();
            chk("nrdy_req", {31'h0, icache_req}, 32'h1);
            chk("nrdy_addr", icache_addr, 32'h200);
            chk("nrdy_cstall", {31'h0, cache_stall}, 32'h1);
            tick();
        end
        icache_ready = 1'b1;
        tick();                             // c21: accept 0x200
        tick();                             // c22

        // Reset in the middle of a request
        exp_addr.push_back(32'h204);
        cache_lat = 2;
        tick();                             // c23: request 0x204
        cache_lat = 1;
        rst_n = 1'b0;
        settle();
        chk_reset_outputs("midreset");
        tick();                             // c24
        rst_n = 1'b1;
        settle();
        chk("late_valid_req", {31'h0, icache_req}, 32'h0);
        chk("late_valid_cstall", {31'h0, cache_stall}, 32'h1);
        exp_addr.push_back(32'h0);
        exp_pc.push_back(32'h0);
        tick();                             // c25: BOOT, late response ignored
        tick();                             // c26: request RESET_PC
        tick();                             // c27

        // PC wrap from 0xFFFF_FFFC
        stall = 1'b1;
        tick();                             // c28: hold PC 0
        exp_addr.push_back(32'hFFFF_FFFC);
        exp_addr.push_back(32'h0);
        exp_pc.push_back(32'hFFFF_FFFC);
        exp_pc.push_back(32'h0);
        jb        = 1'b1;
        jb_target = 32'hFFFF_FFFC;
        tick();                             // c29
        jb    = 1'b0;
        stall = 1'b0;
        repeat (4) tick();                  // c30..c33
        stall = 1'b1;
        tick();                             // c34: PC 0 after wrap

        chk("pending_reqs", exp_addr.size(), 32'h0);
        chk("pending_outs", exp_pc.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
